// File: rtl/vga_pkg.sv
// Shared types and constants for the VGA sprite update path.
package vga_pkg;

  localparam int unsigned VACTIVE  = 480;
  localparam int unsigned VTOTAL   = 525;
  localparam int unsigned VCOUNT_W = 10;
  localparam int unsigned IDX_W    = 8;
  localparam int unsigned DATA_W   = 8;

  typedef enum logic [1:0] {F_POSX, F_POSY, F_SPNUM, F_PBIT} spr_field_t;

  // Index is sized for the largest supported sprite count; the top truncates.
  typedef struct packed {
    logic [IDX_W-1:0]  index;
    spr_field_t        field;
    logic [DATA_W-1:0] data;
  } sprite_upd_t;

  localparam logic [3:0] ADDR_SEL    = 4'd4;
  localparam logic [3:0] ADDR_CTRL   = 4'd5;
  localparam logic [3:0] ADDR_STATUS = 4'd6;
  localparam logic [3:0] ADDR_FRAME  = 4'd7;

  typedef enum logic {ACTIVE, DRAIN} sched_state_t;

endpackage

// File: rtl/sync_fifo.sv
// First-word fall-through synchronous FIFO; push while full is accepted only alongside a pop.
module sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 8,
  localparam int unsigned AW    = $clog2(DEPTH),
  localparam int unsigned CNT_W = AW + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head_c,
  output logic             full_c,
  output logic             empty_c,
  output logic [CNT_W-1:0] count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             push_ok;
  logic             pop_ok;

  assign full_c  = (count == CNT_W'(DEPTH));
  assign empty_c = (count == '0);
  assign head_c  = mem[rd_ptr];
  assign pop_ok  = pop && !empty_c;
  assign push_ok = push && (!full_c || pop_ok);

  // Storage carries no reset; occupancy is tracked by count alone.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
      case ({push_ok, pop_ok})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/sprite_update_sched.sv
// Queues CPU sprite-field writes and replays them into the attribute table during vblank.
module sprite_update_sched #(
  parameter int unsigned DEPTH   = 8,
  parameter int unsigned NSPR    = 16,
  parameter int unsigned VACTIVE = vga_pkg::VACTIVE,
  parameter int unsigned VTOTAL  = vga_pkg::VTOTAL,
  parameter int unsigned GUARD   = 2,
  localparam int unsigned SPR_W  = $clog2(NSPR)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             chipselect,
  input  logic             write,
  input  logic             read,
  input  logic [3:0]       address,
  input  logic [7:0]       writedata,
  output logic [7:0]       readdata,
  input  logic [9:0]       vcount,
  output logic             spr_we,
  output logic [SPR_W-1:0] spr_index,
  output logic [1:0]       spr_field,
  output logic [7:0]       spr_data,
  output logic [7:0]       frame_count,
  output logic             irq
);

  import vga_pkg::sprite_upd_t;
  import vga_pkg::spr_field_t;
  import vga_pkg::sched_state_t;
  import vga_pkg::ACTIVE;
  import vga_pkg::DRAIN;
  import vga_pkg::IDX_W;
  import vga_pkg::ADDR_SEL;
  import vga_pkg::ADDR_CTRL;
  import vga_pkg::ADDR_STATUS;
  import vga_pkg::ADDR_FRAME;

  localparam int unsigned CNT_W  = $clog2(DEPTH) + 1;
  localparam int unsigned FIFO_W = $bits(sprite_upd_t);
  localparam logic [9:0]  VB_LINE   = 10'(VACTIVE);
  localparam logic [9:0]  DRAIN_END = 10'(VTOTAL - GUARD);

  sched_state_t     state;
  sched_state_t     state_nx;
  logic [9:0]       vcount_q;
  logic [SPR_W-1:0] sprite_sel;
  logic             overflow;
  logic             wr_en;
  logic             rd_en;
  logic             push;
  logic             pop;
  logic             vb_start;
  logic             full;
  logic             empty;
  logic [CNT_W-1:0] count;
  sprite_upd_t      push_entry;
  sprite_upd_t      head;

  assign wr_en    = chipselect && write;
  assign rd_en    = chipselect && read;
  assign push     = wr_en && (address[3:2] == 2'b00);
  assign vb_start = (vcount == VB_LINE) && (vcount_q != VB_LINE);

  always_comb begin
    push_entry.index = IDX_W'(sprite_sel);
    push_entry.field = spr_field_t'(address[1:0]);
    push_entry.data  = writedata;
  end

  sync_fifo #(
    .WIDTH (FIFO_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (reset_n),
    .push      (push),
    .push_data (push_entry),
    .pop       (pop),
    .head_c    (head),
    .full_c    (full),
    .empty_c   (empty),
    .count     (count)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= ACTIVE;
    else          state <= state_nx;
  end

  // Pops are confined to the blanking lines ahead of the guard band.
  always_comb begin
    state_nx = state;
    pop      = 1'b0;
    case (state)
      ACTIVE: if (vb_start) state_nx = DRAIN;
      DRAIN: begin
        if (!empty && (vcount >= VB_LINE) && (vcount < DRAIN_END)) pop = 1'b1;
        if (vcount == '0) state_nx = ACTIVE;
      end
      default: state_nx = ACTIVE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      vcount_q    <= '0;
      sprite_sel  <= '0;
      overflow    <= 1'b0;
      irq         <= 1'b0;
      frame_count <= '0;
      spr_we      <= 1'b0;
      spr_index   <= '0;
      spr_field   <= '0;
      spr_data    <= '0;
      readdata    <= '0;
    end else begin
      vcount_q <= vcount;
      if (wr_en && (address == ADDR_SEL)) sprite_sel <= writedata[SPR_W-1:0];

      // Set beats clear when both land in the same cycle.
      if (push && full && !pop)                       overflow <= 1'b1;
      else if (wr_en && (address == ADDR_CTRL) && writedata[0]) overflow <= 1'b0;

      if (vb_start)                                   irq <= 1'b1;
      else if (wr_en && (address == ADDR_CTRL) && writedata[1]) irq <= 1'b0;

      if (vb_start) frame_count <= frame_count + 8'd1;

      spr_we <= pop;
      if (pop) begin
        spr_index <= SPR_W'(head.index);
        spr_field <= head.field;
        spr_data  <= head.data;
      end

      if (rd_en) begin
        case (address)
          ADDR_STATUS: readdata <= {state == DRAIN, irq, overflow, 5'(count)};
          ADDR_FRAME:  readdata <= frame_count;
          ADDR_SEL:    readdata <= 8'(sprite_sel);
          default:     readdata <= '0;
        endcase
      end
    end
  end

endmodule
